// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Optional two's-complement input with sign/magnitude split and overflow flag.
module bcd_seq_conv #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10,
   parameter int SIGNED = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      numero,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  neg,
   output logic                  overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [BW-1:0]    bcd;
   logic [BW-1:0]    adj;
   logic [BW-1:0]    bcd_nx;
   logic [WIDTH-1:0] mag;
   logic [WIDTH-1:0] mag_nx;
   logic [WIDTH-1:0] mag_c;
   logic [CW-1:0]    cnt;
   logic             neg_c;
   logic             neg_w;
   logic             ovf_acc;
   logic             load;
   logic             shift_en;
   logic             fin;

   logic             done_q;
   logic [BW-1:0]    digits_q;
   logic             neg_q;
   logic             ovf_q;

   // capture path: sign split and two's-complement magnitude
   always_comb begin
      neg_c = (SIGNED != 0) && numero[WIDTH-1];
      mag_c = neg_c ? (~numero + WIDTH'(1)) : numero;
   end

   // add-3 correction on every digit that would reach 10 after the shift
   always_comb begin
      adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      bcd_nx = {adj[BW-2:0], mag[WIDTH-1]};
      mag_nx = {mag[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      shift_en = 1'b0;
      fin      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt == CW'(1))
               state_nx = DONE;
         end
         DONE: begin
            fin      = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bcd     <= '0;
         mag     <= '0;
         cnt     <= '0;
         neg_w   <= 1'b0;
         ovf_acc <= 1'b0;
      end else if (load) begin
         bcd     <= '0;
         mag     <= mag_c;
         cnt     <= CW'(WIDTH);
         neg_w   <= neg_c;
         ovf_acc <= 1'b0;
      end else if (shift_en) begin
         bcd     <= bcd_nx;
         mag     <= mag_nx;
         cnt     <= cnt - CW'(1);
         ovf_acc <= ovf_acc | adj[BW-1];
      end
   end

   // result registers only move at the end of DONE, so they stay stable
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         done_q   <= 1'b0;
         digits_q <= '0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= fin;
         if (fin) begin
            digits_q <= bcd;
            neg_q    <= neg_w;
            ovf_q    <= ovf_acc;
         end
      end
   end

   assign busy     = (state != IDLE);
   assign done     = done_q;
   assign digits   = digits_q;
   assign neg      = neg_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Self-checking bench for bcd_seq_conv: vector tables, scoreboard queue,
// held-start, and mid-conversion reset sequences.
module tb_bcd_seq_conv;

   typedef struct {
      int          u;
      logic [31:0] num;
      logic [39:0] dig;
      logic        neg;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [39:0] dig;
      logic        neg;
      logic        ovf;
   } exp_t;

   logic        clock;
   logic        reset_n;
   logic        st [3];
   logic [31:0] nm [3];

   logic        b0, d0, n0, o0;
   logic        b1, d1, n1, o1;
   logic        b2, d2, n2, o2;
   logic [39:0] g0, g1;
   logic [7:0]  g2;

   int   tests;
   int   fails;
   exp_t sbq[$];

   bcd_seq_conv dut0 (
      .clock(clock), .reset_n(reset_n), .start(st[0]), .numero(nm[0]),
      .busy(b0), .done(d0), .digits(g0), .neg(n0), .overflow(o0)
   );

   bcd_seq_conv #(.SIGNED(0)) dut1 (
      .clock(clock), .reset_n(reset_n), .start(st[1]), .numero(nm[1]),
      .busy(b1), .done(d1), .digits(g1), .neg(n1), .overflow(o1)
   );

   bcd_seq_conv #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) dut2 (
      .clock(clock), .reset_n(reset_n), .start(st[2]), .numero(nm[2][7:0]),
      .busy(b2), .done(d2), .digits(g2), .neg(n2), .overflow(o2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic dn(input int u);
      case (u)
         0: return d0;
         1: return d1;
         default: return d2;
      endcase
   endfunction

   function automatic logic [41:0] res(input int u);
      case (u)
         0: return {n0, o0, g0};
         1: return {n1, o1, g1};
         default: return {n2, o2, 32'd0, g2};
      endcase
   endfunction

   // independent decimal model: digits = mag mod 10^nd, ovf if anything left
   function automatic exp_t model(input longint unsigned mag, input int nd,
                                  input logic ng);
      exp_t e;
      longint unsigned m;
      m     = mag;
      e.dig = '0;
      for (int i = 0; i < nd; i++) begin
         e.dig[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      e.ovf = (m != 0);
      e.neg = ng;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic wait_done(input int u, input int explat, input bit rnd);
      int lat;
      exp_t e;
      logic [41:0] r;
      lat = 0;
      while (!dn(u) && lat < 200) begin
         if (rnd) nm[u] = $urandom;
         @(posedge clock); #1;
         lat++;
      end
      if (!dn(u)) begin
         tests++;
         fails++;
         $display("FAIL timeout: unit %0d got no done, expected done", u);
         if (sbq.size() > 0) void'(sbq.pop_front());
      end else begin
         e = sbq.pop_front();
         r = res(u);
         chk("latency", 64'(lat), 64'(explat));
         chk("digits", 64'(r[39:0]), 64'(e.dig));
         chk("neg", 64'(r[41]), 64'(e.neg));
         chk("overflow", 64'(r[40]), 64'(e.ovf));
      end
   endtask

   task automatic conv(input int u, input logic [31:0] v, input exp_t e,
                       input int explat);
      sbq.push_back(e);
      nm[u] = v;
      st[u] = 1'b1;
      @(posedge clock); #1;
      st[u] = 1'b0;
      wait_done(u, explat, 1'b0);
   endtask

   vec_t tbl[$];
   vec_t v;
   exp_t e;
   int   cnt;

   initial begin
      tests   = 0;
      fails   = 0;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0;
         nm[i] = '0;
      end
      #2 reset_n = 1'b0;
      #1;
      chk("rst_busy", 64'(b0), 64'(0));
      chk("rst_done", 64'(d0), 64'(0));
      chk("rst_out", 64'(res(0)), 64'(0));
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;

      tbl.push_back('{0, 32'h000004D2, 40'h0000001234, 1'b0, 1'b0});
      tbl.push_back('{0, 32'hFFFFFF85, 40'h0000000123, 1'b1, 1'b0});
      tbl.push_back('{0, 32'h80000000, 40'h2147483648, 1'b1, 1'b0});
      tbl.push_back('{0, 32'h7FFFFFFF, 40'h2147483647, 1'b0, 1'b0});
      tbl.push_back('{0, 32'hFFFFFFFF, 40'h0000000001, 1'b1, 1'b0});
      tbl.push_back('{0, 32'h00000000, 40'h0000000000, 1'b0, 1'b0});
      tbl.push_back('{1, 32'hFFFFFFFF, 40'h4294967295, 1'b0, 1'b0});
      tbl.push_back('{1, 32'h80000000, 40'h2147483648, 1'b0, 1'b0});
      tbl.push_back('{2, 32'd123, 40'h23, 1'b0, 1'b1});
      tbl.push_back('{2, 32'd99, 40'h99, 1'b0, 1'b0});
      tbl.push_back('{2, 32'd255, 40'h55, 1'b0, 1'b1});
      tbl.push_back('{2, 32'd100, 40'h00, 1'b0, 1'b1});

      foreach (tbl[i]) begin
         v = tbl[i];
         e = '{v.dig, v.neg, v.ovf};
         conv(v.u, v.num, e, (v.u == 2) ? 9 : 33);
      end

      for (int i = 0; i < 6; i++) begin
         logic [31:0] r;
         logic [31:0] m;
         r = $urandom;
         m = r[31] ? (~r + 32'd1) : r;
         conv(0, r, model(64'(m), 10, r[31]), 33);
      end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] r;
         r = 32'($urandom_range(255));
         conv(2, r, model(64'(r), 2, 1'b0), 9);
      end

      // start held high, numero scrambled every cycle while busy
      sbq.push_back(model(64'd1234, 10, 1'b0));
      nm[0] = 32'd1234;
      st[0] = 1'b1;
      @(posedge clock); #1;
      wait_done(0, 33, 1'b1);
      chk("busy_in_done_cycle", 64'(b0), 64'(0));
      sbq.push_back(model(64'd555, 10, 1'b0));
      nm[0] = 32'd555;
      @(posedge clock); #1;
      chk("done_one_cycle", 64'(d0), 64'(0));
      chk("reaccept_busy", 64'(b0), 64'(1));
      wait_done(0, 33, 1'b1);
      st[0] = 1'b0;
      @(posedge clock); #1;

      // leave a nonzero, negative result, then abort a conversion
      conv(0, 32'hFFFFFF85, model(64'd123, 10, 1'b1), 33);
      nm[0] = 32'd4321;
      st[0] = 1'b1;
      @(posedge clock); #1;
      st[0] = 1'b0;
      repeat (10) @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      chk("abort_busy", 64'(b0), 64'(0));
      chk("abort_done", 64'(d0), 64'(0));
      chk("abort_out", 64'(res(0)), 64'(0));
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (d0) cnt++;
      end
      chk("no_done_after_abort", 64'(cnt), 64'(0));
      conv(0, 32'd99, model(64'd99, 10, 1'b0), 33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bcd_seq_conv.md
BCD_SEQ_CONV -- requirements
Module: bcd_seq_conv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the binary input width (legal range 4..64).
REQ-002 The block SHALL have parameter DIGITS, default 10, giving the number of BCD output digits (legal range 1..20).
REQ-003 The block SHALL have parameter SIGNED, default 1: 1 = two's-complement input, 0 = unsigned input.
REQ-004 The block SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port start  input  1  conversion request, sampled on rising edge of clock.
REQ-007 The block SHALL have port numero  input  WIDTH  binary value, captured on the accepted start.
REQ-008 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 The block SHALL have port done  output  1  single-cycle pulse when results become valid.
REQ-010 The block SHALL have port digits  output  4*DIGITS  BCD result, digit 0 (units) in bits [3:0].
REQ-011 The block SHALL have port neg  output  1  sign of the captured value (always 0 when SIGNED=0).
REQ-012 The block SHALL have port overflow  output  1  magnitude does not fit in DIGITS digits.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, DONE; IDLE->SHIFT on start, SHIFT->DONE after exactly WIDTH shift cycles, DONE->IDLE unconditionally.
REQ-014 On start in IDLE, the block SHALL capture neg = SIGNED ? numero[WIDTH-1] : 0, capture magnitude = neg ? (~numero + 1) : numero as WIDTH-bit unsigned, clear the working BCD register and the overflow accumulator, and load the bit counter with WIDTH.
REQ-015 Each SHIFT cycle SHALL, in order: add 3 to every working digit whose value is >= 5, then shift {BCD, magnitude} left one bit, with the magnitude MSB entering digit 0 bit 0.
REQ-016 The bit shifted out of the top digit (digit DIGITS-1, bit 3) SHALL be ORed into the overflow accumulator each SHIFT cycle and otherwise discarded.
REQ-017 Latency SHALL be fixed: done asserts exactly WIDTH+1 cycles after the clock edge that accepts start, independent of value.
REQ-018 In DONE, digits, neg and overflow SHALL be updated together and held stable until the DONE cycle of the next conversion; done SHALL be high for exactly that one cycle.
REQ-019 When overflow=1, digits SHALL equal magnitude mod 10^DIGITS.
REQ-020 busy SHALL be high in SHIFT and DONE and low in IDLE; start while busy SHALL be ignored (no restart, no queuing).
REQ-021 start asserted in the DONE cycle SHALL be ignored; a new request is accepted only in IDLE, giving a maximum throughput of one conversion per WIDTH+2 cycles.
REQ-022 The most-negative input (SIGNED=1, numero = 1 followed by WIDTH-1 zeros) SHALL convert as magnitude 2^(WIDTH-1) with neg=1.
REQ-023 Changes on numero after the accepted start SHALL NOT affect the running conversion.

Reset
REQ-024 Asserting reset_n low SHALL immediately, without a clock, force state IDLE, busy=0, done=0, digits=0, neg=0, overflow=0, and clear all working registers.
REQ-025 Reset asserted mid-conversion SHALL abort it with no done pulse; the first start after reset_n deasserts SHALL be accepted normally.

Verification
REQ-026 Defaults, numero=0x000004D2 (1234), start 1 cycle -> done 33 cycles later, digits=0x0000001234, neg=0, overflow=0.
REQ-027 Defaults, numero=0xFFFFFF85 (-123) -> digits=0x0000000123, neg=1, overflow=0; numero=0x80000000 -> digits=0x2147483648, neg=1.
REQ-028 SIGNED=0, numero=0xFFFFFFFF -> digits=0x4294967295, neg=0, overflow=0.
REQ-029 WIDTH=8, DIGITS=2, SIGNED=0, numero=123 -> done after 9 cycles, digits=0x23, overflow=1; numero=99 -> digits=0x99, overflow=0.
REQ-030 Defaults, start held high through a conversion with numero changing each cycle -> one result for the value at acceptance, next accepted only after return to IDLE; reset_n pulsed low mid-SHIFT -> busy=0, outputs 0 asynchronously, no done.
